// File: rtl/hazard_sched.sv
// Decode-stage hazard scheduler: tracks in-flight register writes through E/M/W,
// stalls decode on a dependency and counts stall cycles. Optional HAZARD_FORWARD_EN.
module hazard_sched #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     validD,
    input  logic                     RegWriteD,
    input  logic [ADDR_W-1:0]        destaddD,
    input  logic [ADDR_W-1:0]        srcaddD1,
    input  logic [ADDR_W-1:0]        srcaddD2,
    input  logic                     useSrcD1,
    input  logic                     useSrcD2,
    input  logic                     holdP,
    output logic                     stallF,
    output logic                     stallD,
    output logic                     flushE,
    output logic [(1<<ADDR_W)-1:0]   pendmask,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [1:0]               fwdselE1,
    output logic [1:0]               fwdselE2
);

    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stages whose match raises a hazard; forwarding covers E and M results.
`ifdef HAZARD_FORWARD_EN
    localparam logic [2:0] HAZ_STAGES = 3'b100;
`else
    localparam logic [2:0] HAZ_STAGES = 3'b111;
`endif

    // Index 0 = E, 1 = M, 2 = W.
    logic [2:0]             vld_q, vld_d;
    logic [2:0][ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             m1, m2;
    logic                   haz;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_match
            assign m1[gi] = vld_q[gi] && (dst_q[gi] == srcaddD1);
            assign m2[gi] = vld_q[gi] && (dst_q[gi] == srcaddD2);
        end
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            assign pendmask[gi] = (vld_q[0] && (dst_q[0] == ADDR_W'(gi)))
                               || (vld_q[1] && (dst_q[1] == ADDR_W'(gi)))
                               || (vld_q[2] && (dst_q[2] == ADDR_W'(gi)));
        end
    endgenerate

    assign haz = validD && ((useSrcD1 && |(m1 & HAZ_STAGES))
                         || (useSrcD2 && |(m2 & HAZ_STAGES)));

    assign stallF    = holdP | haz;
    assign stallD    = holdP | haz;
    assign flushE    = haz & ~holdP;
    assign stall_cnt = cnt_q;

    always_comb begin
        vld_d = vld_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (!holdP) begin
            vld_d[2] = vld_q[1];
            dst_d[2] = dst_q[1];
            vld_d[1] = vld_q[0];
            dst_d[1] = dst_q[0];
            if (haz) begin
                vld_d[0] = 1'b0;
                dst_d[0] = '0;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                vld_d[0] = validD & RegWriteD;
                dst_d[0] = destaddD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    // Youngest producer wins: E-stage result (now moving to M) before M (moving to W).
    function automatic logic [1:0] fwd_code(input logic use_src, input logic [2:0] m);
        if (!use_src)  return 2'b00;
        else if (m[0]) return 2'b01;
        else if (m[1]) return 2'b10;
        else           return 2'b00;
    endfunction

    always_comb begin
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
        if (!holdP) begin
            if (haz) begin
                fwd1_d = 2'b00;
                fwd2_d = 2'b00;
            end else begin
                fwd1_d = fwd_code(useSrcD1, m1);
                fwd2_d = fwd_code(useSrcD2, m2);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd1_q <= 2'b00;
            fwd2_q <= 2'b00;
        end else begin
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign fwdselE1 = fwd1_q;
    assign fwdselE2 = fwd2_q;
`else
    assign fwdselE1 = 2'b00;
    assign fwdselE2 = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: expected stall lengths are queued when an
// instruction is presented and compared when decode finally accepts it.
module tb_hazard_sched;

    localparam int AW = 4;
    localparam int CW = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 validD = 1'b0, RegWriteD = 1'b0;
    logic [AW-1:0]        destaddD = '0, srcaddD1 = '0, srcaddD2 = '0;
    logic                 useSrcD1 = 1'b0, useSrcD2 = 1'b0, holdP = 1'b0;
    logic                 stallF, stallD, flushE;
    logic [(1<<AW)-1:0]   pendmask;
    logic [CW-1:0]        stall_cnt;
    logic [1:0]           fwdselE1, fwdselE2;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int exp_cnt = 0;

    hazard_sched #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .validD(validD), .RegWriteD(RegWriteD),
        .destaddD(destaddD), .srcaddD1(srcaddD1), .srcaddD2(srcaddD2),
        .useSrcD1(useSrcD1), .useSrcD2(useSrcD2), .holdP(holdP),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .pendmask(pendmask),
        .stall_cnt(stall_cnt), .fwdselE1(fwdselE1), .fwdselE2(fwdselE2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic drive(input logic rw, input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic u1, input logic u2);
        validD = 1'b1; RegWriteD = rw; destaddD = dst;
        srcaddD1 = s1; srcaddD2 = s2; useSrcD1 = u1; useSrcD2 = u2;
    endtask

    task automatic idle(input int n);
        validD = 1'b0; RegWriteD = 1'b0; useSrcD1 = 1'b0; useSrcD2 = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > CNT_SAT) ? CNT_SAT : a + b;
    endfunction

    // Count stall cycles until the presented instruction is accepted, then score it.
    task automatic accept(input string tag);
        int n = 0;
        bit done = 0;
        int exp;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stallF !== stallD) check_val({tag, "_stallF"}, stallF, stallD);
            if (stallD) begin
                n++;
                if (flushE !== 1'b1) check_val({tag, "_flushE"}, flushE, 1'b1);
            end else begin
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check_val({tag, "_timeout"}, 0, 1);
        exp = exp_q.pop_front();
        check_val({tag, "_stalls"}, n, exp);
        exp_cnt = sat_add(exp_cnt, exp);
        check_val({tag, "_cnt"}, stall_cnt, exp_cnt);
    endtask

    task automatic issue(input string tag, input logic rw, input logic [AW-1:0] dst,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic u1, input logic u2, input int exp_stalls);
        exp_q.push_back(exp_stalls);
        drive(rw, dst, s1, s2, u1, u2);
        accept(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check_val("rst_stallD", stallD, 1'b0);
        check_val("rst_flushE", flushE, 1'b0);
        check_val("rst_pend", pendmask, 16'h0000);
        check_val("rst_cnt", stall_cnt, 0);
        check_val("rst_fwd1", fwdselE1, 2'b00);
        #2 reset = 1'b0;
        @(posedge clk); #1;

`ifdef HAZARD_FORWARD_EN
        issue("fw_prod0", 1, 7, 0, 0, 0, 0, 0);
        issue("fw_cons0", 0, 0, 7, 0, 1, 0, 0);
        check_val("fw_sel_m", fwdselE1, 2'b01);
        idle(3);
        issue("fw_prod1", 1, 7, 0, 0, 0, 0, 0);
        issue("fw_gap1", 1, 9, 0, 0, 0, 0, 0);
        issue("fw_cons1", 0, 0, 7, 0, 1, 0, 0);
        check_val("fw_sel_w", fwdselE1, 2'b10);
        idle(3);
        issue("fw_prod2", 1, 7, 0, 0, 0, 0, 0);
        issue("fw_gap2a", 1, 9, 0, 0, 0, 0, 0);
        issue("fw_gap2b", 1, 10, 0, 0, 0, 0, 0);
        issue("fw_cons2", 0, 0, 7, 0, 1, 0, 1);
        check_val("fw_sel_rf", fwdselE1, 2'b00);
        idle(3);
        issue("fw_prod3", 1, 6, 0, 0, 0, 0, 0);
        issue("fw_cons3", 0, 0, 1, 6, 1, 1, 0);
        check_val("fw_sel2_m", fwdselE2, 2'b01);
        check_val("fw_sel1_rf", fwdselE1, 2'b00);
`else
        // Independent stream: bits 1 and 2 walk out of the tracking pipe.
        issue("ind_r1", 1, 1, 5, 6, 1, 1, 0);
        issue("ind_r2", 1, 2, 5, 6, 1, 1, 0);
        check_val("ind_pend0", pendmask, 16'h0006);
        idle(1); check_val("ind_pend1", pendmask, 16'h0006);
        idle(1); check_val("ind_pend2", pendmask, 16'h0004);
        idle(1); check_val("ind_pend3", pendmask, 16'h0000);

        issue("raw_prod", 1, 4, 0, 0, 0, 0, 0);
        issue("raw_cons", 0, 0, 4, 0, 1, 0, 3);
        check_val("raw_pend", pendmask, 16'h0000);
        check_val("raw_fwd", fwdselE1, 2'b00);
        idle(3);

        issue("g1_prod", 1, 4, 0, 0, 0, 0, 0);
        issue("g1_mid", 1, 9, 0, 0, 0, 0, 0);
        issue("g1_cons", 0, 0, 4, 0, 1, 0, 2);
        idle(3);
        issue("g2_prod", 1, 4, 0, 0, 0, 0, 0);
        issue("g2_mid1", 1, 9, 0, 0, 0, 0, 0);
        issue("g2_mid2", 1, 10, 0, 0, 0, 0, 0);
        issue("g2_cons", 0, 0, 4, 0, 1, 0, 1);
        idle(3);

        issue("same_prod", 1, 8, 0, 0, 0, 0, 0);
        issue("same_cons", 0, 0, 8, 8, 1, 1, 3);
        idle(3);
        issue("self_wr", 1, 3, 3, 1, 1, 1, 0);
        issue("self_rd", 0, 0, 3, 0, 1, 0, 3);
        idle(3);
        issue("nouse_prod", 1, 4, 0, 0, 0, 0, 0);
        issue("nouse_cons", 0, 0, 4, 0, 0, 0, 0);
        idle(3);

        // Freeze during a 3-cycle hazard.
        issue("hold_prod", 1, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 4, 0, 1, 0);
        @(negedge clk);
        check_val("hold_pre_stall", stallD, 1'b1);
        check_val("hold_pre_flush", flushE, 1'b1);
        @(posedge clk); #1;
        exp_cnt = sat_add(exp_cnt, 1);
        holdP = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("hold_stallD", stallD, 1'b1);
            check_val("hold_flushE", flushE, 1'b0);
            check_val("hold_pend", pendmask, 16'h0010);
            check_val("hold_cnt", stall_cnt, exp_cnt);
            @(posedge clk); #1;
        end
        holdP = 1'b0;
        exp_q.push_back(2);
        accept("hold_rest");
        idle(3);

        // Counter saturates instead of wrapping.
        issue("sat_prod", 1, 5, 0, 0, 0, 0, 0);
        issue("sat_cons", 0, 0, 5, 0, 1, 0, 3);
        idle(3);
`endif

        // Reset in the middle of a stall.
        issue("mr_prod", 1, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 4, 0, 1);
        @(negedge clk);
        check_val("mr_stall_pre", stallD, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_val("mr_stallD", stallD, 1'b0);
        check_val("mr_flushE", flushE, 1'b0);
        check_val("mr_pend", pendmask, 16'h0000);
        check_val("mr_cnt", stall_cnt, 0);
        exp_cnt = 0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        issue("mr_after", 0, 0, 0, 4, 0, 1, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Decode-stage hazard scheduler for the 4-stage D/E/M/W pipeline.
- Tracks in-flight register writes (destination address plus write-enable) through E, M and W.
- Stalls fetch/decode and injects a bubble into the execute register when a decode operand depends on an in-flight write.
- Honours an external pipeline freeze and keeps a saturating stall statistic.

Parameters:
- ADDR_W, 4: register-address width (16 registers, no hardwired zero).
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- validD  in  1  decode slot holds a real instruction
- RegWriteD  in  1  decode instruction writes the register file
- destaddD  in  ADDR_W  decode destination register
- srcaddD1  in  ADDR_W  decode source 1 address
- srcaddD2  in  ADDR_W  decode source 2 address
- useSrcD1  in  1  source 1 is read
- useSrcD2  in  1  source 2 is read
- holdP  in  1  external freeze (memory busy): whole pipeline holds
- stallF  out  1  hold the fetch PC/register
- stallD  out  1  hold the decode register
- flushE  out  1  load a bubble into the execute register (RegWriteE=MemWriteE=0)
- pendmask  out  2^ADDR_W  bit r set while any tracked stage writes register r
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
- fwdselE1  out  2  source-1 forward select, aligned to E: 00 regfile, 01 from M, 10 from W
- fwdselE2  out  2  source-2 forward select, same encoding as fwdselE1

Behaviour:
- Tracking pipe: three entries S0(E), S1(M), S2(W), each {vld, dst}.
- Register file writes at end of the W cycle, no read bypass; all three stages count as in flight.
- match(a) = any Sk.vld with Sk.dst==a. hazD = validD & ((useSrcD1 & match(srcaddD1)) | (useSrcD2 & match(srcaddD2))).
- Combinational outputs:
  - stallF = stallD = holdP | hazD.
  - flushE = hazD & ~holdP.
  - pendmask = OR over vld stages of onehot(dst).
- Per-clock update:
  - If holdP: all Sk, fwdsel, stall_cnt hold.
  - Else if hazD: S0 <= bubble (vld=0); S1<=S0; S2<=S1.
  - Else: S0 <= {validD & RegWriteD, destaddD}; S1<=S0; S2<=S1.
- Stalls resolve: a dependency on S0 stalls exactly 3 cycles, on S1 2 cycles, on S2 1 cycle (non-forwarding build).
- Same register as both sources: one check, same stall length.
- A decode instruction writing its own source (r3<=r3+r1) checks sources only against older stages; no self-hazard.
- stall_cnt: +1 on each cycle with hazD & ~holdP; saturates at 2^CNT_W-1, no wrap.
- Simultaneous holdP and hazD: freeze wins, no bubble, counter unchanged.
- Reset (asynchronous, any cycle, including mid-stall):
  - All Sk.vld=0, dst=0; stall_cnt=0; fwdselE1/E2=00.
  - Hence stallF=stallD=flushE=0 (unless holdP=1, then stallF=stallD=1) and pendmask=0.
  - Pending dependencies are discarded.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- Defined:
  - Matches in S0 and S1 do not raise hazD; only S2 matches stall (1 cycle).
  - On a non-stalled, non-held advance, fwdselEn <= 01 if srcaddDn matches S0, else 10 if it matches S1 (youngest wins), else 00; useSrcDn=0 gives 00.
  - On a bubble, fwdselEn <= 00.
- Undefined: fwdselE1/E2 are constant 00; full stall behaviour as above.

Test Plan:
- Independent stream r1<=.., r2<=.., reads r5/r6 -> stallD never 1, stall_cnt=0, pendmask shows bits 1,2 walking out after 3 cycles.
- Write r4 then immediately read r4 (src1) -> stallD=1 and flushE=1 for 3 cycles, stall_cnt=3, consumer enters E on 4th cycle; pendmask[4] clears when producer leaves W.
- Write r4, independent instr, then read r4 -> 2 stall cycles; with a 2-instruction gap -> 1 cycle.
- holdP=1 for 5 cycles during a 3-cycle hazard -> stallD=1 throughout, flushE=0 while held, stall_cnt ends at 3, tracking pipe unchanged across hold.
- Reset pulsed mid-stall -> outputs to reset values asynchronously, pendmask=0, next cycle same read proceeds with no stall.
- HAZARD_FORWARD_EN: write r7 then read r7 -> no stall, fwdselE1=01 in consumer's E cycle; one-gap case -> fwdselE1=10; two-gap -> 1 stall cycle, fwdsel 00.
